usb_nrzi_receiver: RTL and testbench

Receive-side front end of the USB serial path: the counterpart of the transmit-side parallel-in/serial-out shifter.
- Samples the differential line once per bit period and NRZI-decodes it.
- Hunts for SYNC, removes stuffed bits and assembles bytes LSB-first.
- Detects EOP and flags stuffing, line and alignment errors.
- Feeds the packet/PID layer with one byte strobe per received byte.

---
 rtl/usb_rx_pkg.sv | 23 ++
 rtl/usb_nrzi_receiver_nrzi_decoder.sv | 45 ++++
 rtl/usb_nrzi_receiver.sv | 197 +++++++++++++++++++
 tb/tb_usb_nrzi_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and line encodings for the USB receive front end.
// {dp, dm} codes for the two idle-capable differential states.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2,
    SE1 = 2'd3
  } line_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    EOP1 = 3'd2,
    EOP2 = 3'd3,
    ERR  = 3'd4
  } rx_state_t;

  localparam logic [1:0] J_LINE = 2'b10;
  localparam logic [1:0] K_LINE = 2'b01;

endpackage

// File: rtl/usb_nrzi_receiver_nrzi_decoder.sv
// Classifies each bit-centre sample into a line state and NRZI-decodes J/K samples
// against the previous J/K level (SE0 restores the idle J reference).
module nrzi_decoder
  import usb_rx_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  bit_en_i,
  input  logic  dp_i,
  input  logic  dm_i,
  output line_t line_o,
  output logic  bit_o
);

  line_t prev_q, prev_d;
  line_t line;

  always_comb begin
    unique case ({dp_i, dm_i})
      J_LINE:  line = J;
      K_LINE:  line = K;
      2'b00:   line = SE0;
      default: line = SE1;
    endcase
  end

  // A repeated level is a 1; any transition is a 0.
  assign bit_o  = ((line == J) || (line == K)) && (line == prev_q);
  assign line_o = line;

  always_comb begin
    prev_d = prev_q;
    if (bit_en_i) begin
      if ((line == J) || (line == K)) prev_d = line;
      else if (line == SE0)           prev_d = J;
    end
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= J;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/usb_nrzi_receiver.sv
// USB receive front end: SYNC hunt, bit-unstuffing, LSB-first byte assembly and EOP
// detection with registered one-cycle status pulses for the packet layer.
module usb_nrzi_receiver
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = 6,
  parameter int SYNC_ZEROS  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       pkt_active,
  output logic       pkt_done,
  output logic       stuff_err,
  output logic       line_err,
  output logic       align_err
);

  localparam logic [2:0] STUFF_LIMIT_C = 3'(STUFF_LIMIT);
  localparam logic [2:0] SYNC_ZEROS_C  = 3'(SYNC_ZEROS);

  line_t     line;
  logic      dbit;

  rx_state_t state_q, state_d;
  logic [2:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       prev_se0_q, prev_se0_d;
  logic       pkt_active_q, pkt_active_d;
  logic       byte_valid_q, byte_valid_d;
  logic       pkt_done_q, pkt_done_d;
  logic       stuff_err_q, stuff_err_d;
  logic       line_err_q, line_err_d;
  logic       align_err_q, align_err_d;

  nrzi_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .bit_en_i (bit_en),
    .dp_i     (dp_in),
    .dm_i     (dm_in),
    .line_o   (line),
    .bit_o    (dbit)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    zero_cnt_d   = zero_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    prev_se0_d   = prev_se0_q;
    pkt_active_d = pkt_active_q;
    byte_valid_d = 1'b0;
    pkt_done_d   = 1'b0;
    stuff_err_d  = 1'b0;
    line_err_d   = 1'b0;
    align_err_d  = 1'b0;

    if (bit_en) begin
      prev_se0_d = (line == SE0);
      unique case (state_q)
        IDLE: begin
          if ((line == J) || (line == K)) begin
            if (!dbit) begin
              if (zero_cnt_q != SYNC_ZEROS_C) zero_cnt_d = zero_cnt_q + 3'd1;
            end else if (zero_cnt_q >= SYNC_ZEROS_C) begin
              state_d      = DATA;
              pkt_active_d = 1'b1;
              ones_cnt_d   = 3'd1;
              bit_cnt_d    = 3'd0;
              zero_cnt_d   = 3'd0;
            end else begin
              zero_cnt_d = 3'd0;
            end
          end else begin
            zero_cnt_d = 3'd0;
          end
        end

        DATA: begin
          unique case (line)
            J, K: begin
              if (ones_cnt_q == STUFF_LIMIT_C) begin
                // The stuff check runs before the shift, so a violating 1 never lands in a byte.
                if (dbit) begin
                  stuff_err_d  = 1'b1;
                  pkt_active_d = 1'b0;
                  state_d      = ERR;
                end else begin
                  ones_cnt_d = 3'd0;
                end
              end else begin
                shift_d    = {dbit, shift_q[6:1]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                ones_cnt_d = dbit ? ones_cnt_q + 3'd1 : 3'd0;
                if (bit_cnt_q == 3'd7) begin
                  rx_byte_d    = {dbit, shift_q};
                  byte_valid_d = 1'b1;
                end
              end
            end
            SE0: state_d = EOP1;
            default: begin
              line_err_d   = 1'b1;
              pkt_active_d = 1'b0;
              state_d      = ERR;
            end
          endcase
        end

        EOP1: begin
          if (line == SE0) begin
            state_d = EOP2;
          end else begin
            line_err_d   = 1'b1;
            pkt_active_d = 1'b0;
            state_d      = ERR;
          end
        end

        EOP2: begin
          pkt_active_d = 1'b0;
          if (line == J) begin
            pkt_done_d  = 1'b1;
            align_err_d = (bit_cnt_q != 3'd0);
            zero_cnt_d  = 3'd0;
            state_d     = IDLE;
          end else begin
            line_err_d = 1'b1;
            state_d    = ERR;
          end
        end

        ERR: begin
          pkt_active_d = 1'b0;
          if ((line == J) && prev_se0_q) begin
            zero_cnt_d = 3'd0;
            state_d    = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      zero_cnt_q   <= '0;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      prev_se0_q   <= 1'b0;
      pkt_active_q <= 1'b0;
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      stuff_err_q  <= 1'b0;
      line_err_q   <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      zero_cnt_q   <= zero_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      prev_se0_q   <= prev_se0_d;
      pkt_active_q <= pkt_active_d;
      byte_valid_q <= byte_valid_d;
      pkt_done_q   <= pkt_done_d;
      stuff_err_q  <= stuff_err_d;
      line_err_q   <= line_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign pkt_active = pkt_active_q;
  assign pkt_done   = pkt_done_q;
  assign stuff_err  = stuff_err_q;
  assign line_err   = line_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_usb_nrzi_receiver.sv
// Packet-level bench: a transmit-side encoder (stuffing + NRZI) builds line traffic from
// byte lists, and the expected byte/EOP/error events come from what was sent.
module tb_usb_nrzi_receiver;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       dp_in, dm_in;
  logic [7:0] rx_byte;
  logic       byte_valid, pkt_active, pkt_done, stuff_err, line_err, align_err;

  usb_nrzi_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .dp_in      (dp_in),
    .dm_in      (dm_in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .pkt_active (pkt_active),
    .pkt_done   (pkt_done),
    .stuff_err  (stuff_err),
    .line_err   (line_err),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Observed event log, filled away from the active edge.
  logic [7:0] obs_bytes[$];
  logic       obs_align[$];
  int         obs_stuff, obs_line, obs_stray;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) obs_bytes.push_back(rx_byte);
      if (pkt_done) obs_align.push_back(align_err);
      if (align_err && !pkt_done) obs_stray++;
      if (stuff_err) obs_stuff++;
      if (line_err) obs_line++;
    end
  end

  // Transmit-side model state and expectations.
  line_t      tb_level;
  int         tb_ones;
  int         gap;
  logic [7:0] tx_bytes[$];
  logic [7:0] exp_bytes[$];
  int         exp_done, exp_stuff, exp_line;
  logic       exp_align;

  function automatic logic [1:0] line_code(input line_t l);
    case (l)
      J:       return J_LINE;
      K:       return K_LINE;
      SE0:     return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  task automatic clear_log();
    obs_bytes.delete();
    obs_align.delete();
    obs_stuff = 0;
    obs_line  = 0;
    obs_stray = 0;
    exp_bytes.delete();
    exp_done  = 0;
    exp_stuff = 0;
    exp_line  = 0;
    exp_align = 1'b0;
  endtask

  // One bit_en sample, then `gap` idle cycles with the lines wandering.
  task automatic send_line(input line_t l);
    {dp_in, dm_in} = line_code(l);
    bit_en = 1'b1;
    if (l == J || l == K) tb_level = l;
    else if (l == SE0)    tb_level = J;
    @(posedge clk); #1;
    bit_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      {dp_in, dm_in} = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bit(input logic b);
    send_line(b ? tb_level : ((tb_level == J) ? K : J));
  endtask

  task automatic send_data_bit(input logic b, input bit stuff_en);
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
    if (stuff_en && tb_ones == 6) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
  endtask

  task automatic send_sync(input int extra_zeros);
    send_line(J);
    for (int i = 0; i < 7 + extra_zeros; i++) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
  endtask

  task automatic send_eop();
    send_line(SE0);
    send_line(SE0);
    send_line(J);
  endtask

  task automatic finish_pkt(input string tag);
    int n;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s nbytes", tag), obs_bytes.size(), exp_bytes.size());
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), obs_bytes[i], exp_bytes[i]);
    if (exp_bytes.size() > 0)
      check($sformatf("%s rx_hold", tag), rx_byte, exp_bytes[exp_bytes.size()-1]);
    check($sformatf("%s done", tag), obs_align.size(), exp_done);
    if (obs_align.size() > 0 && exp_done > 0)
      check($sformatf("%s align", tag), obs_align[0], exp_align);
    check($sformatf("%s stuff_err", tag), obs_stuff, exp_stuff);
    check($sformatf("%s line_err", tag), obs_line, exp_line);
    check($sformatf("%s stray_align", tag), obs_stray, 0);
    check($sformatf("%s active_end", tag), pkt_active, 1'b0);
    clear_log();
  endtask

  // Full well-formed packet from tx_bytes plus `partial` trailing data bits.
  task automatic send_packet(input string tag, input int partial, input int extra_zeros);
    send_sync(extra_zeros);
    check($sformatf("%s active_sync", tag), pkt_active, 1'b1);
    foreach (tx_bytes[k]) begin
      exp_bytes.push_back(tx_bytes[k]);
      for (int i = 0; i < 8; i++) send_data_bit(tx_bytes[k][i], 1'b1);
    end
    for (int i = 0; i < partial; i++) send_data_bit(1'($urandom), 1'b1);
    send_eop();
    exp_done  = 1;
    exp_align = (partial != 0);
    finish_pkt(tag);
  endtask

  task automatic recover();
    send_line(SE0);
    send_line(J);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bit_en = 1'b0; {dp_in, dm_in} = J_LINE;
    tb_level = J; tb_ones = 0; gap = 0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, rx_byte}, 32'd0);
    check("reset_flags", {byte_valid, pkt_active, pkt_done, stuff_err, line_err, align_err}, 6'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed 8'hA5 packet, back-to-back samples.
    tx_bytes = '{8'hA5};
    send_packet("a5", 0, 0);

    // 8'hFF needs one stuffed 0 after the 5th data 1.
    tx_bytes = '{8'hFF};
    send_packet("ff", 0, 0);

    // Stuffing violation, then recovery and a clean packet.
    send_sync(0);
    for (int i = 0; i < 7; i++) send_data_bit(1'b1, 1'b0);
    exp_stuff = 1;
    check("stuff active_drop", pkt_active, 1'b0);
    recover();
    finish_pkt("stuff");
    tx_bytes = '{8'h3C, 8'h7E};
    send_packet("post_stuff", 0, 0);

    // Partial byte before EOP.
    tx_bytes.delete();
    send_packet("partial5", 5, 0);

    // Malformed EOP after one byte.
    send_sync(0);
    for (int i = 0; i < 8; i++) send_data_bit(8'h5A >> i, 1'b1);
    exp_bytes.push_back(8'h5A);
    send_line(SE0);
    send_line(K);
    exp_line = 1;
    recover();
    finish_pkt("eop_k");

    // SE1 inside DATA.
    send_sync(0);
    for (int i = 0; i < 3; i++) send_data_bit(1'b0, 1'b1);
    send_line(SE1);
    exp_line = 1;
    recover();
    finish_pkt("se1");

    // Asynchronous reset mid-byte: outputs clear without waiting for an edge.
    tx_bytes = '{8'hC3};
    send_packet("pre_rst", 0, 0);
    send_sync(0);
    for (int i = 0; i < 3; i++) send_data_bit(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_mid flags", {byte_valid, pkt_active, pkt_done, stuff_err, line_err, align_err}, 6'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tb_level = J; tb_ones = 0;
    clear_log();
    tx_bytes = '{8'h96};
    send_packet("post_rst", 0, 0);

    // Same A5 packet with 10 idle cycles between samples.
    gap = 10;
    tx_bytes = '{8'hA5};
    send_packet("a5_gap", 0, 0);

    // Randomized packets: byte count, contents, trailing bits, sample spacing, SYNC length.
    for (int p = 0; p < 24; p++) begin
      gap = $urandom_range(0, 3);
      tx_bytes.delete();
      for (int k = 0; k < $urandom_range(0, 4); k++)
        tx_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      send_packet($sformatf("rnd%0d", p),
                  ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
                  $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
